cordic_rot_engine: RTL and testbench
====================================

Name: cordic_rot_engine

Overview:
- Iterative CORDIC rotation-mode engine that computes cos/sin of a 16.16 fixed-point angle in degrees.
- It is the consumer of xita_tan_lut: it drives the LUT iteration index `i` and consumes the returned arctan(2^-i) angle `xita` once per iteration.
- Sits between the angle source (controller/host registers) and downstream users of sin/cos.
- One result per start request; start/busy/done handshake.

Parameters:
- ITERS, 16, number of CORDIC micro-rotations; legal range 1..21.
- K_INIT, 32'sd39797, CORDIC gain compensation 0.607253 in Q16.16; loaded into x at start.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on posedge only while idle.
- angle_in  input  32  signed Q16.16 degrees; legal range -180.0..+180.0 inclusive.
- i  output  5  iteration index to LUT; registered.
- xita  input  32  LUT angle, Q16.16 degrees, unsigned magnitude; bit 31 ignored (treated as 0).
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results are updated.
- err  output  1  one-cycle pulse when start is rejected for an out-of-range angle.
- cos_out  output  32  signed Q16.16 result.
- sin_out  output  32  signed Q16.16 result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; i, busy, done, err = 0.
  - cos_out, sin_out = 0; x, y, z, neg registers = 0.
- LUT timing contract:
  - The LUT updates xita on negedge clk.
  - i is changed only on posedge, so xita(i) is stable at the following posedge.
  - No extra prime cycle is needed.
- States: IDLE, ITER.
- IDLE, start=1, |angle_in| <= 180<<16 (E0):
  - Quadrant fold:
    - angle > 90<<16: z = angle - (180<<16), neg=1.
    - angle < -(90<<16): z = angle + (180<<16), neg=1.
    - Otherwise z = angle, neg=0.
  - x = K_INIT; y = 0; i = 0; busy=1; state=ITER.
- IDLE, start=1, angle out of range:
  - err=1 for one cycle; state stays IDLE; outputs unchanged; done not asserted.
- ITER, each posedge E_k (k=1..ITERS), using current i=k-1:
  - d = +1 if z >= 0 (signed), else -1.
  - x <= x - d*(y >>> i); y <= y + d*(x >>> i); z <= z - d*{1'b0, xita[30:0]}.
  - `>>>` is an arithmetic shift; all arithmetic is 32-bit signed and wraps (no saturation).
  - i <= i+1.
- At E_ITERS:
  - The final iteration is applied and results are written in the same edge.
  - cos_out = neg ? -x_next : x_next; sin_out = neg ? -y_next : y_next.
  - done=1, busy=0, i=0, state=IDLE.
- Latency: done is high in the cycle after edge E_ITERS, exactly ITERS clocks after the start-sampling edge. Throughput is one result per ITERS+1 clocks minimum.
- done and err are single-cycle pulses and are cleared on the next posedge.
- Back-to-back: start may be high in the same cycle done is high; it is accepted at that edge.
- start while busy: ignored, with no queuing and no err.
- cos_out/sin_out hold their last value until the next done; they are not disturbed during iteration.
- Reset mid-operation: immediate return to reset values; any partial result is discarded; no done.
- Accuracy (ITERS=16): |error| <= 16 LSB versus ideal Q16.16 for all legal angles.
- Exact boundaries ±90 and ±180 degrees use the fold rules above: ±90 is not folded, ±180 is folded to 0 with neg=1.

Test Plan:
- Reset then start, angle_in=0:
  - done exactly 16 clocks after the start edge.
  - cos_out ≈ 65536, sin_out ≈ 0 (±16).
  - i sequence 0..15 observed on consecutive cycles.
- angle_in=30<<16 (0x001E0000) → cos ≈ 56756, sin ≈ 32768; angle_in=90<<16 → cos ≈ 0, sin ≈ 65536 (±16).
- Quadrant fold:
  - angle_in=150<<16 → cos ≈ -56756, sin ≈ 32768.
  - angle_in=-(120<<16) → cos ≈ -32768, sin ≈ -56756.
  - angle_in=180<<16 → cos ≈ -65536, sin ≈ 0.
- angle_in=181<<16 with start → one-cycle err, no busy, no done; cos/sin retain the previous result.
- Protocol:
  - Start pulse mid-computation is ignored.
  - Start asserted in the done cycle begins a new run, with the next done 16 clocks later.
- Drop rst_n at iteration 7 → busy, i, done, cos_out, sin_out all 0 immediately; a subsequent start for 45<<16 yields cos ≈ sin ≈ 46341.

Source files
------------

// File: rtl/cordic_rot_engine_if.sv
// Host-side handshake for the CORDIC rotation engine: angle request in,
// busy/done/err status and cos/sin results out.
interface cordic_rot_engine_if;
  logic        start;
  logic [31:0] angle_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cos_out;
  logic [31:0] sin_out;

  modport master (
    output start, angle_in,
    input  busy, done, err, cos_out, sin_out
  );

  modport slave (
    input  start, angle_in,
    output busy, done, err, cos_out, sin_out
  );
endinterface

// File: rtl/cordic_rot_engine.sv
// Iterative CORDIC rotation engine: cos/sin of a Q16.16 degree angle, one
// micro-rotation per clock using the arctan value returned by an external LUT.
module cordic_rot_engine #(
  parameter int                 ITERS  = 16,
  parameter logic signed [31:0] K_INIT = 32'sd39797
) (
  input  logic                clk,
  input  logic                rst_n,
  cordic_rot_engine_if.slave  host,
  output logic [4:0]          i,
  input  logic [31:0]         xita
);

  typedef enum logic {IDLE, ITER} state_t;

  localparam logic signed [31:0] LIM180 = 32'sd11796480;
  localparam logic signed [31:0] LIM90  = 32'sd5898240;
  localparam logic [4:0]         LAST   = 5'(ITERS - 1);

  state_t             state, state_n;
  logic [4:0]         i_q, i_n;
  logic signed [31:0] x, x_n, y, y_n, z, z_n;
  logic               neg, neg_n;
  logic               busy_q, busy_n, done_q, done_n, err_q, err_n;
  logic signed [31:0] cos_q, cos_n, sin_q, sin_n;

  logic signed [31:0] ang, x_step, y_step, z_step, atan_mag;
  logic               in_range;

  assign ang      = $signed(host.angle_in);
  assign in_range = (ang >= -LIM180) && (ang <= LIM180);
  assign atan_mag = $signed(xita & 32'h7FFF_FFFF);

  // One micro-rotation; direction chosen to drive the residual angle z toward 0.
  always_comb begin
    if (z >= 32'sd0) begin
      x_step = x - (y >>> i_q);
      y_step = y + (x >>> i_q);
      z_step = z - atan_mag;
    end else begin
      x_step = x + (y >>> i_q);
      y_step = y - (x >>> i_q);
      z_step = z + atan_mag;
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i_q;
    x_n     = x;
    y_n     = y;
    z_n     = z;
    neg_n   = neg;
    busy_n  = busy_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    cos_n   = cos_q;
    sin_n   = sin_q;
    case (state)
      IDLE: begin
        if (host.start) begin
          if (in_range) begin
            // Fold outer quadrants into +-90 so the rotation converges; negate at the end.
            if (ang > LIM90) begin
              z_n   = ang - LIM180;
              neg_n = 1'b1;
            end else if (ang < -LIM90) begin
              z_n   = ang + LIM180;
              neg_n = 1'b1;
            end else begin
              z_n   = ang;
              neg_n = 1'b0;
            end
            x_n     = K_INIT;
            y_n     = 32'sd0;
            i_n     = 5'd0;
            busy_n  = 1'b1;
            state_n = ITER;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ITER: begin
        x_n = x_step;
        y_n = y_step;
        z_n = z_step;
        if (i_q == LAST) begin
          cos_n   = neg ? -x_step : x_step;
          sin_n   = neg ? -y_step : y_step;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          i_n     = 5'd0;
          state_n = IDLE;
        end else begin
          i_n = i_q + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      i_q    <= 5'd0;
      x      <= 32'sd0;
      y      <= 32'sd0;
      z      <= 32'sd0;
      neg    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cos_q  <= 32'sd0;
      sin_q  <= 32'sd0;
    end else begin
      state  <= state_n;
      i_q    <= i_n;
      x      <= x_n;
      y      <= y_n;
      z      <= z_n;
      neg    <= neg_n;
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
      cos_q  <= cos_n;
      sin_q  <= sin_n;
    end
  end

  assign i            = i_q;
  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.err     = err_q;
  assign host.cos_out = cos_q;
  assign host.sin_out = sin_q;

endmodule

// File: tb/tb_cordic_rot_engine.sv
// Bench for cordic_rot_engine: arctan LUT model plus ideal cos/sin reference,
// directed protocol steps followed by random angles.
module tb_cordic_rot_engine;

  localparam real PI     = 3.14159265358979323846;
  localparam int  DEG180 = 11796480;
  localparam int  TOL    = 16;

  logic        clk;
  logic        rst_n;
  logic [4:0]  i;
  logic [31:0] xita;
  int          passed;
  int          total;

  cordic_rot_engine_if host();

  cordic_rot_engine #(.ITERS(16), .K_INIT(32'sd39797)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host),
    .i     (i),
    .xita  (xita)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // arctan(2^-idx) in Q16.16 degrees; bit 31 is set as junk the engine must ignore.
  function automatic logic [31:0] lutAngle(input int idx);
    real p;
    p = 1.0;
    for (int k = 0; k < idx; k++) p = p / 2.0;
    return 32'h8000_0000 | 32'($rtoi($atan(p) * 180.0 / PI * 65536.0 + 0.5));
  endfunction

  always @(negedge clk) xita <= lutAngle(int'(i));

  function automatic int roundReal(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic real idealCos(input logic [31:0] ang);
    return 65536.0 * $cos(real'($signed(ang)) / 65536.0 * PI / 180.0);
  endfunction

  function automatic real idealSin(input logic [31:0] ang);
    return 65536.0 * $sin(real'($signed(ang)) / 65536.0 * PI / 180.0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkNear(input string tag, input logic [31:0] obs, input real ideal);
    int  e;
    int  d;
    logic ok;
    e  = roundReal(ideal);
    d  = $signed(obs) - e;
    ok = (d <= TOL) && (d >= -TOL);
    total++;
    assert (ok === 1'b1) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d+-%0d", tag, $signed(obs), e, TOL);
  endtask

  // Issue one start and count edges until done (bounded).
  task automatic applyStimulus(input logic [31:0] ang, output int lat);
    host.start    = 1'b1;
    host.angle_in = ang;
    @(posedge clk); #1;
    host.start = 1'b0;
    lat = 0;
    while (host.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [31:0] ang);
    int lat;
    applyStimulus(ang, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd16);
    checkNear({tag, "_cos"}, host.cos_out, idealCos(ang));
    checkNear({tag, "_sin"}, host.sin_out, idealSin(ang));
  endtask

  initial begin
    int          lat;
    logic [31:0] ang;
    passed        = 0;
    total         = 0;
    rst_n         = 1'b0;
    host.start    = 1'b0;
    host.angle_in = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(host.busy), 32'd0);
    checkOutput("rst_done", 32'(host.done), 32'd0);
    checkOutput("rst_err",  32'(host.err),  32'd0);
    checkOutput("rst_i",    32'(i),         32'd0);
    checkOutput("rst_cos",  host.cos_out,   32'd0);
    checkOutput("rst_sin",  host.sin_out,   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Angle 0 with the LUT index sequence observed cycle by cycle
    host.start    = 1'b1;
    host.angle_in = 32'd0;
    @(posedge clk); #1;
    host.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checkOutput("iseq_i", 32'(i), 32'(k));
      checkOutput("iseq_busy", 32'(host.busy), 32'd1);
      @(posedge clk); #1;
    end
    checkOutput("a0_done", 32'(host.done), 32'd1);
    checkOutput("a0_busy", 32'(host.busy), 32'd0);
    checkOutput("a0_i",    32'(i),         32'd0);
    checkNear("a0_cos", host.cos_out, 65536.0);
    checkNear("a0_sin", host.sin_out, 0.0);
    @(posedge clk); #1;
    checkOutput("done_pulse", 32'(host.done), 32'd0);

    // Directed angles, including fold boundaries
    runAndCheck("a30",   32'(30 <<< 16));
    runAndCheck("a90",   32'(90 <<< 16));
    runAndCheck("a150",  32'(150 <<< 16));
    runAndCheck("am120", 32'(-(120 <<< 16)));
    runAndCheck("am90",  32'(-(90 <<< 16)));
    runAndCheck("am180", 32'(-DEG180));
    runAndCheck("a180",  32'(DEG180));

    // Out-of-range requests: err pulse, no run, result retained from 180
    for (int k = 0; k < 3; k++) begin
      ang = (k == 0) ? 32'(181 <<< 16) : (k == 1) ? 32'(-(181 <<< 16)) : 32'(DEG180 + 1);
      @(posedge clk); #1;
      host.start    = 1'b1;
      host.angle_in = ang;
      @(posedge clk); #1;
      host.start = 1'b0;
      checkOutput("oor_err",  32'(host.err),  32'd1);
      checkOutput("oor_busy", 32'(host.busy), 32'd0);
      checkOutput("oor_done", 32'(host.done), 32'd0);
      @(posedge clk); #1;
      checkOutput("oor_err_clr", 32'(host.err),  32'd0);
      checkOutput("oor_done2",   32'(host.done), 32'd0);
      checkNear("oor_cos_hold", host.cos_out, -65536.0);
      checkNear("oor_sin_hold", host.sin_out, 0.0);
    end

    // Start pulse mid-computation is ignored
    host.start    = 1'b1;
    host.angle_in = 32'(30 <<< 16);
    @(posedge clk); #1;
    host.start = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    host.start    = 1'b1;
    host.angle_in = 32'(60 <<< 16);
    @(posedge clk); #1;
    lat++;
    host.start = 1'b0;
    checkOutput("mid_err", 32'(host.err), 32'd0);
    while (host.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checkOutput("mid_latency", 32'(lat), 32'd16);
    checkNear("mid_cos", host.cos_out, idealCos(32'(30 <<< 16)));
    checkNear("mid_sin", host.sin_out, idealSin(32'(30 <<< 16)));
    @(posedge clk); #1;
    checkOutput("mid_no_rerun", 32'(host.busy), 32'd0);

    // Back-to-back: second start lands in the done cycle of the first
    runAndCheck("b2b_a", 32'(30 <<< 16));
    runAndCheck("b2b_b", 32'(-(45 <<< 16)));

    // Reset at iteration 7 discards everything
    @(posedge clk); #1;
    host.start    = 1'b1;
    host.angle_in = 32'(60 <<< 16);
    @(posedge clk); #1;
    host.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("pre_rst_i", 32'(i), 32'd7);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_busy", 32'(host.busy), 32'd0);
    checkOutput("mrst_i",    32'(i),         32'd0);
    checkOutput("mrst_done", 32'(host.done), 32'd0);
    checkOutput("mrst_cos",  host.cos_out,   32'd0);
    checkOutput("mrst_sin",  host.sin_out,   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runAndCheck("a45", 32'(45 <<< 16));

    // Random legal angles against the ideal reference
    for (int k = 0; k < 24; k++) begin
      ang = 32'(int'($urandom_range(2 * DEG180, 0)) - DEG180);
      runAndCheck("rand", ang);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
